// File: rtl/posit_avmm_csr.sv
// Avalon-MM CSR front-end for the posit core.
// It latches the operands and op, issues one valid/ready request, captures the result,
// and reports status, latency, timeout and an interrupt.
module posit_avmm_csr #(
  parameter int unsigned NBITS          = 32,
  parameter int unsigned OP_W           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             avs_readdatavalid,
  output logic             irq,
  output logic             core_req_valid,
  input  logic             core_req_ready,
  output logic [NBITS-1:0] core_num1,
  output logic [NBITS-1:0] core_num2,
  output logic [OP_W-1:0]  core_op,
  input  logic             core_resp_valid,
  input  logic [NBITS-1:0] core_result
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned LAT_W  = 16;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LAT_W-1:0]  LAT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             r_state,   w_state_nxt;
  logic [NBITS-1:0]   r_num1,    w_num1_nxt;
  logic [NBITS-1:0]   r_num2,    w_num2_nxt;
  logic [NBITS-1:0]   r_result,  w_result_nxt;
  logic [OP_W-1:0]    r_op,      w_op_nxt;
  logic               r_irq_en,  w_irq_en_nxt;
  logic               r_done,    w_done_nxt;
  logic               r_tmo,     w_tmo_nxt;
  logic               r_err,     w_err_nxt;
  logic [LAT_W-1:0]   r_lat,     w_lat_nxt;
  logic [TCNT_W-1:0]  r_tcnt,    w_tcnt_nxt;
  logic [31:0]        r_rdata,   w_rdata_nxt;
  logic               r_rvalid,  w_rvalid_nxt;
  logic               r_irq,     w_irq_nxt;
  logic               r_req_vld, w_req_vld_nxt;
  logic               w_busy;

  // Bus decode, request FSM and status next-state logic.
  always_comb begin
    w_busy        = (r_state != S_IDLE);
    w_state_nxt   = r_state;
    w_num1_nxt    = r_num1;
    w_num2_nxt    = r_num2;
    w_result_nxt  = r_result;
    w_op_nxt      = r_op;
    w_irq_en_nxt  = r_irq_en;
    w_done_nxt    = r_done;
    w_tmo_nxt     = r_tmo;
    w_err_nxt     = r_err;
    w_lat_nxt     = r_lat;
    w_tcnt_nxt    = r_tcnt;
    w_rdata_nxt   = r_rdata;
    w_rvalid_nxt  = 1'b0;

    // Register writes; operand/op/start are locked out while an operation is in flight.
    if (avs_write) begin
      case (avs_address)
        3'd0: begin
          if (w_busy) w_err_nxt  = 1'b1;
          else        w_num1_nxt = avs_writedata[NBITS-1:0];
        end
        3'd1: begin
          if (w_busy) w_err_nxt  = 1'b1;
          else        w_num2_nxt = avs_writedata[NBITS-1:0];
        end
        3'd2: begin
          w_irq_en_nxt = avs_writedata[2];
          if (avs_writedata[1]) begin
            w_done_nxt = 1'b0;
            w_tmo_nxt  = 1'b0;
            w_err_nxt  = 1'b0;
          end
          if (w_busy) begin
            if (avs_writedata[0]) w_err_nxt = 1'b1;
          end else begin
            w_op_nxt = avs_writedata[8 +: OP_W];
            if (avs_writedata[0]) begin
              w_state_nxt = S_ISSUE;
              w_done_nxt  = 1'b0;
              w_tmo_nxt   = 1'b0;
              w_lat_nxt   = '0;
              w_tcnt_nxt  = '0;
            end
          end
        end
        default: ;
      endcase
    end

    // Request FSM; completion and timeout are applied after CLR so they take priority.
    case (r_state)
      S_ISSUE: begin
        if (r_lat != LAT_MAX) w_lat_nxt = r_lat + 16'd1;
        if (core_req_ready && core_resp_valid) begin
          w_state_nxt  = S_IDLE;
          w_result_nxt = core_result;
          w_done_nxt   = 1'b1;
        end else if (r_tcnt == TCNT_LAST) begin
          w_state_nxt = S_IDLE;
          w_tmo_nxt   = 1'b1;
        end else begin
          w_tcnt_nxt = r_tcnt + TCNT_W'(1);
          if (core_req_ready) w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_lat != LAT_MAX) w_lat_nxt = r_lat + 16'd1;
        if (core_resp_valid) begin
          w_state_nxt  = S_IDLE;
          w_result_nxt = core_result;
          w_done_nxt   = 1'b1;
        end else if (r_tcnt == TCNT_LAST) begin
          w_state_nxt = S_IDLE;
          w_tmo_nxt   = 1'b1;
        end else begin
          w_tcnt_nxt = r_tcnt + TCNT_W'(1);
        end
      end
      default: ;
    endcase

    w_req_vld_nxt = (w_state_nxt == S_ISSUE);
    w_irq_nxt     = w_irq_en_nxt & (w_done_nxt | w_tmo_nxt);

    // Read data from current register values; a colliding write drops the read.
    if (avs_read && !avs_write) begin
      w_rvalid_nxt = 1'b1;
      w_rdata_nxt  = '0;
      case (avs_address)
        3'd0: w_rdata_nxt = 32'(r_num1);
        3'd1: w_rdata_nxt = 32'(r_num2);
        3'd2: begin
          w_rdata_nxt[2]         = r_irq_en;
          w_rdata_nxt[8 +: OP_W] = r_op;
        end
        3'd3: w_rdata_nxt = {r_lat, 12'd0, r_err, r_tmo, r_done, w_busy};
        3'd4: w_rdata_nxt = 32'(r_result);
        default: w_rdata_nxt = '0;
      endcase
    end
  end

  // State and register file.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_num1    <= '0;
      r_num2    <= '0;
      r_result  <= '0;
      r_op      <= '0;
      r_irq_en  <= 1'b0;
      r_done    <= 1'b0;
      r_tmo     <= 1'b0;
      r_err     <= 1'b0;
      r_lat     <= '0;
      r_tcnt    <= '0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_irq     <= 1'b0;
      r_req_vld <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_num1    <= w_num1_nxt;
      r_num2    <= w_num2_nxt;
      r_result  <= w_result_nxt;
      r_op      <= w_op_nxt;
      r_irq_en  <= w_irq_en_nxt;
      r_done    <= w_done_nxt;
      r_tmo     <= w_tmo_nxt;
      r_err     <= w_err_nxt;
      r_lat     <= w_lat_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_irq     <= w_irq_nxt;
      r_req_vld <= w_req_vld_nxt;
    end
  end

  assign avs_readdata      = r_rdata;
  assign avs_readdatavalid = r_rvalid;
  assign irq               = r_irq;
  assign core_req_valid    = r_req_vld;
  assign core_num1         = r_num1;
  assign core_num2         = r_num2;
  assign core_op           = r_op;

endmodule

// File: tb/tb_posit_avmm_csr.sv
// Self-checking bench for posit_avmm_csr with a directed/randomized core handshake.
module tb_posit_avmm_csr;

  localparam int unsigned NB  = 32;
  localparam int unsigned OW  = 4;
  localparam int unsigned TMO = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic [2:0]    avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;
  logic          avs_readdatavalid;
  logic          irq;
  logic          core_req_valid;
  logic          core_req_ready = 1'b0;
  logic [NB-1:0] core_num1;
  logic [NB-1:0] core_num2;
  logic [OW-1:0] core_op;
  logic          core_resp_valid = 1'b0;
  logic [NB-1:0] core_result = '0;

  int checks = 0;
  int errors = 0;

  // Reference state of the programmer-visible registers.
  logic [31:0] m_num1, m_num2, m_result;
  logic [3:0]  m_op;
  bit          m_irq_en, m_done, m_tmo, m_err;
  int          m_lat;

  posit_avmm_csr #(.NBITS(NB), .OP_W(OW), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_n(reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .irq(irq),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_num1(core_num1), .core_num2(core_num2), .core_op(core_op),
    .core_resp_valid(core_resp_valid), .core_result(core_result)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {16'(m_lat), 12'd0, m_err, m_tmo, m_done, 1'b0};
  endfunction

  function automatic logic m_irq();
    return m_irq_en & (m_done | m_tmo);
  endfunction

  task automatic model_reset();
    m_num1 = '0; m_num2 = '0; m_result = '0; m_op = '0;
    m_irq_en = 0; m_done = 0; m_tmo = 0; m_err = 0; m_lat = 0;
  endtask

  // Idle-time register write; starts and ends on a falling edge.
  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    avs_write = 1'b1; avs_address = a; avs_writedata = d;
    @(negedge clock);
    avs_write = 1'b0;
    case (a)
      3'd0: m_num1 = d;
      3'd1: m_num2 = d;
      3'd2: begin
        m_irq_en = d[2];
        m_op = d[11:8];
        if (d[1]) begin m_done = 0; m_tmo = 0; m_err = 0; end
        if (d[0]) begin m_done = 0; m_tmo = 0; m_lat = 0; end
      end
      default: ;
    endcase
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    avs_read = 1'b1; avs_address = a;
    @(negedge clock);
    avs_read = 1'b0;
    chk("readdatavalid", 32'(avs_readdatavalid), 32'd1);
    d = avs_readdata;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  // Plays the core for one request issued by the preceding START write.
  // Ready in busy cycle rdy, response rsp cycles after acceptance; no response = timeout.
  task automatic run_op(input int rdy, input int rsp, input logic [31:0] res, input bit respond,
                        input int wr_cyc, input logic [2:0] wr_a, input logic [31:0] wr_d);
    int total;
    total = respond ? rdy + rsp : int'(TMO);
    for (int i = 1; i <= total; i++) begin
      chk("req_valid", 32'(core_req_valid), 32'(i <= rdy));
      chk("core_num1", core_num1, m_num1);
      chk("core_num2", core_num2, m_num2);
      chk("core_op", 32'(core_op), 32'(m_op));
      core_req_ready  = (i == rdy);
      core_resp_valid = respond && (i == total);
      core_result     = (respond && i == total) ? res : $urandom;
      if (i == wr_cyc) begin
        avs_write = 1'b1; avs_address = wr_a; avs_writedata = wr_d; m_err = 1;
      end else begin
        avs_write = 1'b0;
      end
      @(negedge clock);
    end
    core_req_ready = 1'b0; core_resp_valid = 1'b0; avs_write = 1'b0;
    core_result = $urandom;
    if (respond) begin m_result = res; m_done = 1; end
    else m_tmo = 1;
    m_lat = total;
    chk("req_valid_end", 32'(core_req_valid), 32'd0);
    chk("irq_end", 32'(irq), 32'(m_irq()));
  endtask

  initial begin
    logic [31:0] d, r;
    int rdy, rsp;
    model_reset();
    #1 reset_n = 1'b0;
    #3;
    chk("rst_readdata", avs_readdata, 32'd0);
    chk("rst_rvalid", 32'(avs_readdatavalid), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_req_valid", 32'(core_req_valid), 32'd0);
    chk("rst_num1", core_num1, 32'd0);
    chk("rst_op", 32'(core_op), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    rd_chk(3'd3, 32'd0, "rst_status");
    rd_chk(3'd4, 32'd0, "rst_result");

    // Basic operation with irq, then CLR.
    bus_wr(3'd0, 32'h4000_0000);
    bus_wr(3'd1, 32'h4800_0000);
    bus_wr(3'd2, 32'h0000_0005);
    run_op(2, 3, 32'h4C00_0000, 1, 0, 3'd0, 32'd0);
    rd_chk(3'd4, 32'h4C00_0000, "t2_result");
    rd_chk(3'd3, 32'h0005_0002, "t2_status");
    chk("t2_irq", 32'(irq), 32'd1);
    bus_wr(3'd2, 32'h0000_0006);
    chk("t2_irq_clr", 32'(irq), 32'd0);
    rd_chk(3'd3, m_status(), "t2_status_clr");

    // Busy write to NUM1 is rejected and flags err.
    bus_wr(3'd2, 32'h0000_0301);
    run_op(3, 2, 32'h5A5A_0001, 1, 2, 3'd0, 32'h1234_5678);
    rd_chk(3'd0, m_num1, "t4_num1");
    rd_chk(3'd3, m_status(), "t4_status");
    rd_chk(3'd4, m_result, "t4_result");
    bus_wr(3'd2, 32'h0000_0002);

    // Response in the acceptance cycle.
    bus_wr(3'd2, 32'h0000_0001);
    run_op(1, 0, 32'h3C00_0000, 1, 0, 3'd0, 32'd0);
    rd_chk(3'd3, 32'h0001_0002, "t3_status");
    rd_chk(3'd4, 32'h3C00_0000, "t3_result");

    // Randomized operations.
    for (int k = 0; k < 8; k++) begin
      bus_wr(3'd0, $urandom);
      bus_wr(3'd1, $urandom);
      bus_wr(3'd2, ($urandom_range(0, 15) << 8) | ($urandom_range(0, 1) << 2) | 32'h1);
      rdy = $urandom_range(1, 4);
      rsp = $urandom_range(0, 4);
      run_op(rdy, rsp, $urandom, 1, (k % 3 == 0) ? 1 : 0, 3'd1, $urandom);
      rd_chk(3'd4, m_result, "rnd_result");
      rd_chk(3'd3, m_status(), "rnd_status");
      rd_chk(3'd1, m_num2, "rnd_num2");
      bus_wr(3'd2, {20'd0, m_op, 5'd0, m_irq_en, 2'b10});
      chk("rnd_irq_clr", 32'(irq), 32'd0);
    end

    // Core never answers: timeout, then a late response is ignored.
    bus_wr(3'd2, 32'h0000_0005);
    run_op(TMO + 1, 0, 32'd0, 0, 0, 3'd0, 32'd0);
    rd_chk(3'd3, 32'h0010_0004, "t5_status");
    chk("t5_irq", 32'(irq), 32'd1);
    core_resp_valid = 1'b1; core_result = 32'hDEAD_BEEF;
    @(negedge clock);
    core_resp_valid = 1'b0;
    rd_chk(3'd4, m_result, "t5_late_result");
    rd_chk(3'd3, m_status(), "t5_late_status");
    bus_wr(3'd2, 32'h0000_0002);

    // Unmapped read, ignored write, read/write collision.
    rd_chk(3'd0, m_num1, "t6_num1");
    rd_chk(3'd6, 32'd0, "t6_addr6");
    @(negedge clock);
    chk("t6_rvalid_once", 32'(avs_readdatavalid), 32'd0);
    bus_wr(3'd6, 32'hFFFF_FFFF);
    rd_chk(3'd7, 32'd0, "t6_addr7");
    d = $urandom;
    avs_read = 1'b1; avs_write = 1'b1; avs_address = 3'd1; avs_writedata = d;
    @(negedge clock);
    avs_read = 1'b0; avs_write = 1'b0;
    m_num2 = d;
    chk("t6_collide_rvalid", 32'(avs_readdatavalid), 32'd0);
    rd_chk(3'd1, m_num2, "t6_collide_num2");

    // Asynchronous reset mid-ISSUE (ph 0) and mid-WAIT (ph 1).
    for (int ph = 0; ph < 2; ph++) begin
      bus_wr(3'd2, 32'h0000_0005);
      r = $urandom | 32'h1;
      run_op(1, 1, r, 1, 0, 3'd0, 32'd0);
      bus_wr(3'd2, 32'h0000_0005);
      core_req_ready = (ph == 1);
      @(negedge clock);
      core_req_ready = 1'b0;
      @(negedge clock);
      chk("t1_req_before", 32'(core_req_valid), 32'(ph == 0));
      #2 reset_n = 1'b0;
      #1;
      chk("t1_req_async", 32'(core_req_valid), 32'd0);
      chk("t1_irq_async", 32'(irq), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      rd_chk(3'd3, 32'd0, "t1_status");
      rd_chk(3'd4, 32'd0, "t1_result");
      rd_chk(3'd0, 32'd0, "t1_num1");
      chk("t1_req_after", 32'(core_req_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
